// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and constants for the PLL reset controller.
// State encoding, default timing parameters and the counter-width helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } pll_rst_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 7;

  // One spare bit above the largest terminal count so saturation never aliases.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_rst_ctrl_sync_2ff.sv
// Generic two-flop synchroniser for signals arriving asynchronously to i_clk.
// The reset clears both stages so the downstream logic sees a known level.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= i_d;
      sync_reg <= meta_reg;
    end
  end

  assign o_q = sync_reg;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases the core reset.
// Optional failed-attempt counter on o_retries when PLL_RST_CTRL_STATUS_EN is defined.
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_locked,
  output logic       o_pll_rst,
  output logic       o_rst_req,
  output logic       o_fail
`ifdef PLL_RST_CTRL_STATUS_EN
  ,
  output logic [7:0] o_retries
`endif
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
  localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

  logic lock_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_locked),
    .o_q   (lock_s)
  );

  pll_rst_state_t state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [7:0]     retry_reg;
  logic           pll_rst_reg;
  logic           rst_req_reg;
  logic           fail_reg;

  logic [CW-1:0]  cnt_inc;
  logic [7:0]     retry_inc;
  logic           timeout_hit;

  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign retry_inc = retry_reg + 8'd1;
  // Lock has priority: a lock seen on the last timeout cycle is not a failure.
  assign timeout_hit = (state_reg == ST_WAIT_LOCK) && !lock_s && (cnt_reg == TO_LAST);

  // Outputs are updated on the same edge as the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_PLLRST;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      pll_rst_reg <= 1'b1;
      rst_req_reg <= 1'b1;
      fail_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_PLLRST: begin
          if (cnt_reg == RST_LAST) begin
            state_reg   <= ST_WAIT_LOCK;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
          end else if (timeout_hit) begin
            retry_reg <= retry_inc;
            cnt_reg   <= '0;
            if (retry_inc == RETRY_LIMIT) begin
              state_reg <= ST_FAIL;
              fail_reg  <= 1'b1;
            end else begin
              state_reg   <= ST_PLLRST;
              pll_rst_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_reg <= ST_WAIT_LOCK;
            cnt_reg   <= '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            retry_reg   <= '0;
            rst_req_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_reg   <= ST_PLLRST;
            cnt_reg     <= '0;
            pll_rst_reg <= 1'b1;
            rst_req_reg <= 1'b1;
          end
        end
        ST_FAIL: begin
          state_reg <= ST_FAIL;
        end
        default: begin
          state_reg   <= ST_PLLRST;
          cnt_reg     <= '0;
          retry_reg   <= '0;
          pll_rst_reg <= 1'b1;
          rst_req_reg <= 1'b1;
          fail_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign o_pll_rst = pll_rst_reg;
  assign o_rst_req = rst_req_reg;
  assign o_fail    = fail_reg;

`ifdef PLL_RST_CTRL_STATUS_EN
  // Lifetime failure count since i_rst; unlike retry_reg it survives RUN entry.
  logic [7:0] retries_total_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      retries_total_reg <= 8'd0;
    end else if (timeout_hit && (retries_total_reg != 8'hFF)) begin
      retries_total_reg <= retries_total_reg + 8'd1;
    end
  end

  assign o_retries = retries_total_reg;
`endif

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Directed bench for pll_rst_ctrl: expected latencies queued at stimulus time, checked on output events.
// Exercises o_retries as well when PLL_RST_CTRL_STATUS_EN is defined.
module tb_pll_rst_ctrl;

  localparam int RC = 4;
  localparam int TO = 20;
  localparam int SC = 8;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic pll_rst;
  logic rst_req;
  logic fail;
`ifdef PLL_RST_CTRL_STATUS_EN
  logic [7:0] retries;
`endif

  pll_rst_ctrl #(
    .RST_CYCLES    (RC),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_locked  (locked),
    .o_pll_rst (pll_rst),
    .o_rst_req (rst_req),
    .o_fail    (fail)
`ifdef PLL_RST_CTRL_STATUS_EN
    ,
    .o_retries (retries)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pll_rises = 0;
  always @(posedge pll_rst) pll_rises <= pll_rises + 1;

  int n_asserts = 0;
  int n_fail = 0;
  int exp_q[$];

  function automatic logic sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return rst_req;
      default: return fail;
    endcase
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[%0t] %s observed=%0d expected=%0d", $time, tag, obs, exp);
  endtask

  task automatic sb_push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input int obs);
    int e;
    if (exp_q.size() == 0) begin
      n_asserts++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL %s: scoreboard empty, observed %0d", tag, obs);
      end
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // Wait (bounded) at negedges for a DUT output to reach a level; returns the edge index.
  task automatic wait_sig(input int which, input logic val, input int budget,
                          input string tag, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sig(which) === val) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_asserts++;
      assert (at >= 0) else begin
        n_fail++;
        $error("FAIL %s: level %0b not seen within %0d cycles", tag, val, budget);
      end
    end
  endtask

  // Two-cycle reset with output checks; t is the last edge that sampled reset high.
  task automatic apply_reset(input string tag, output int t);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pll_rst"}, int'(pll_rst), 1);
    check({tag, "_rst_req"}, int'(rst_req), 1);
    check({tag, "_fail"}, int'(fail), 0);
`ifdef PLL_RST_CTRL_STATUS_EN
    check({tag, "_retries"}, int'(retries), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    t = cyc;
  endtask

  initial begin
    int t0, t1, t2, tw, tr, tf, r0;

    // Clean bring-up: lock 5 cycles after WAIT_LOCK entry
    locked = 1'b0;
    apply_reset("a_rst", t0);
    sb_push(RC);
    wait_sig(0, 1'b0, 50, "a_pll_fall", tw);
    sb_check("a_pll_width", tw - t0);
    r0 = pll_rises;
    repeat (5) @(posedge clk);
    #1 locked = 1'b1;
    sb_push(5 + 2 + SC + 1);
    wait_sig(1, 1'b0, 100, "a_release", tr);
    sb_check("a_release_latency", tr - tw);
    check("a_extra_pll_pulses", pll_rises - r0, 0);
    check("a_fail_flag", int'(fail), 0);

    // Lock loss in RUN, then full re-sequence
    @(posedge clk);
    #1 locked = 1'b0;
    t1 = cyc;
    sb_push(3);
    wait_sig(1, 1'b1, 20, "d_req_rise", tr);
    sb_check("d_req_rise_latency", tr - t1);
    check("d_pll_rst_same_edge", int'(pll_rst), 1);
    sb_push(RC);
    wait_sig(0, 1'b0, 20, "d_pll_fall", tw);
    sb_check("d_pll_width", tw - tr);
    repeat (2) @(posedge clk);
    #1 locked = 1'b1;
    sb_push(2 + 2 + SC + 1);
    wait_sig(1, 1'b0, 100, "d_release", tr);
    sb_check("d_release_latency", tr - tw);

    // Lock glitch in STABLE restarts the stable count without a PLL reset
    locked = 1'b0;
    apply_reset("c_rst", t0);
    wait_sig(0, 1'b0, 50, "c_pll_fall", tw);
    locked = 1'b1;
    r0 = pll_rises;
    repeat (6) @(posedge clk);
    #1 locked = 1'b0;
    @(posedge clk);
    #1 locked = 1'b1;
    sb_push(6 + 4 + SC);
    wait_sig(1, 1'b0, 100, "c_release", tr);
    sb_check("c_release_latency", tr - tw);
    check("c_no_pll_pulse", pll_rises - r0, 0);

    // Timeout retries until FAIL
    locked = 1'b0;
    apply_reset("b_rst", t0);
    sb_push(RC);
    wait_sig(0, 1'b0, 50, "b_fall1", tw);
    sb_check("b_width1", tw - t0);
    sb_push(TO + RC);
    wait_sig(0, 1'b1, 60, "b_rise2", t1);
    sb_check("b_spacing1", t1 - t0);
    sb_push(RC);
    wait_sig(0, 1'b0, 50, "b_fall2", tw);
    sb_check("b_width2", tw - t1);
    sb_push(TO + RC);
    wait_sig(0, 1'b1, 60, "b_rise3", t2);
    sb_check("b_spacing2", t2 - t1);
    sb_push(RC);
    wait_sig(0, 1'b0, 50, "b_fall3", tw);
    sb_check("b_width3", tw - t2);
    sb_push(MR * (TO + RC));
    wait_sig(2, 1'b1, 60, "b_fail_rise", tf);
    sb_check("b_fail_time", tf - t0);
    check("b_fail_pll_rst", int'(pll_rst), 0);
    locked = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("b_fail_sticky", int'(fail), 1);
    check("b_fail_rst_req", int'(rst_req), 1);
    check("b_fail_pll_idle", int'(pll_rst), 0);

    // Reset mid-attempt after two timeouts; three more timeouts needed
    locked = 1'b0;
    apply_reset("e_rst0", t0);
    wait_sig(0, 1'b0, 50, "e_fall1", tw);
    wait_sig(0, 1'b1, 60, "e_rise2", tw);
    wait_sig(0, 1'b0, 50, "e_fall2", tw);
    wait_sig(0, 1'b1, 60, "e_rise3", tw);
    wait_sig(0, 1'b0, 50, "e_fall3", tw);
    repeat (5) @(posedge clk);
    r0 = pll_rises;
    apply_reset("e_rst1", t1);
    sb_push(MR * (TO + RC));
    sb_push(MR);
    wait_sig(2, 1'b1, 120, "e_fail_rise", tf);
    sb_check("e_fail_time", tf - t1);
    sb_check("e_pll_pulses", pll_rises - r0);

`ifdef PLL_RST_CTRL_STATUS_EN
    // Two timeouts then success; total count survives RUN and a lock loss
    locked = 1'b0;
    apply_reset("f_rst0", t0);
    wait_sig(0, 1'b0, 50, "f_fall1", tw);
    wait_sig(0, 1'b1, 60, "f_rise2", tw);
    wait_sig(0, 1'b0, 50, "f_fall2", tw);
    wait_sig(0, 1'b1, 60, "f_rise3", tw);
    wait_sig(0, 1'b0, 50, "f_fall3", tw);
    locked = 1'b1;
    sb_push(2);
    wait_sig(1, 1'b0, 100, "f_release", tr);
    sb_check("f_retries_run", int'(retries));
    @(posedge clk);
    #1 locked = 1'b0;
    wait_sig(1, 1'b1, 20, "f_req_rise", tr);
    wait_sig(0, 1'b0, 20, "f_pll_fall", tw);
    locked = 1'b1;
    sb_push(2);
    wait_sig(1, 1'b0, 100, "f_release2", tr);
    sb_check("f_retries_after_loss", int'(retries));
    apply_reset("f_rst1", t1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
